// File: rtl/sim_done_sequencer.sv
// -----------------------------------------------------------------------------
// sim_done_sequencer
//
// End-of-simulation controller for mLingua benches. It collects per-checker
// done/fail flags, ignores them during an arm window after start, waits a
// drain window once every checker has reported done, and then raises a single
// level `finish` for the bench's finish_sim instance. It also reports the
// pass/timeout status for the final message.
//
// Optional feature macro: SIM_SEQ_WATCHDOG_EN
//   defined   : the watchdog moves ARM/RUN to TOUT when `elapsed` reaches
//               TIMEOUT_CYC.
//   undefined : TOUT is never entered and `timeout` stays 0. `elapsed` still
//               counts and saturates.
//
// Ports:
//   clk        in   bench clock; all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   begin sequencing; sampled only in IDLE
//   done_in    in   [NO_SIG] per-checker done level/pulse
//   fail_in    in   [NO_SIG] per-checker failure level/pulse
//   finish     out  high in DONE/TOUT; drives finish_sim.in
//   pass       out  valid when finish=1
//   timeout    out  watchdog fired
//   done_seen  out  [NO_SIG] sticky done capture
//   state      out  [3] state encoding (IDLE=0 ARM=1 RUN=2 DRAIN=3 DONE=4 TOUT=5)
//   elapsed    out  [CW] cycles since start, saturating
//
// All outputs come from registers, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module sim_done_sequencer #(
    parameter int NO_SIG      = 4,
    parameter int ARM_CYC     = 16,
    parameter int DRAIN_CYC   = 8,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CW          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NO_SIG-1:0] done_in,
    input  logic [NO_SIG-1:0] fail_in,
    output logic              finish,
    output logic              pass,
    output logic              timeout,
    output logic [NO_SIG-1:0] done_seen,
    output logic [2:0]        state,
    output logic [CW-1:0]     elapsed
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_TOUT  = 3'd5
    } state_t;

    // One window counter serves both ARM and DRAIN; size it for the longer one.
    localparam int WIN_MAX = (ARM_CYC > DRAIN_CYC) ? ARM_CYC : DRAIN_CYC;
    localparam int WIN_W   = $clog2(WIN_MAX + 2);

    localparam logic [WIN_W-1:0] ARM_LAST   = WIN_W'((ARM_CYC   > 0) ? ARM_CYC   - 1 : 0);
    localparam logic [WIN_W-1:0] DRAIN_LAST = WIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);
    localparam logic [WIN_W-1:0] WIN_ONE    = WIN_W'(1);
    localparam logic [CW-1:0]    EL_MAX     = {CW{1'b1}};
    localparam logic [CW-1:0]    EL_ONE     = CW'(1);
    localparam logic             ARM_SKIP   = (ARM_CYC   == 0) ? 1'b1 : 1'b0;
    localparam logic             DRAIN_SKIP = (DRAIN_CYC == 0) ? 1'b1 : 1'b0;
`ifdef SIM_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0]    TOUT_LIM   = CW'(TIMEOUT_CYC);
`endif

    state_t              r_state;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [NO_SIG-1:0]   r_done_seen;
    logic [NO_SIG-1:0]   r_fail_seen;
    logic [CW-1:0]       r_elapsed;
    logic                r_finish;
    logic                r_pass;
    logic                r_timeout;

    state_t              w_state_nxt;
    logic [WIN_W-1:0]    w_win_cnt_nxt;
    logic [NO_SIG-1:0]   w_done_seen_nxt;
    logic [NO_SIG-1:0]   w_fail_seen_nxt;
    logic [CW-1:0]       w_elapsed_nxt;
    logic [CW-1:0]       w_elapsed_inc;
    logic                w_wdog_hit;
    logic                w_finish_nxt;
    logic                w_pass_nxt;
    logic                w_timeout_nxt;

    // Saturating increment of the elapsed-cycle counter.
    always_comb begin
        w_elapsed_inc = r_elapsed;
        if (r_elapsed == EL_MAX) begin
            w_elapsed_inc = r_elapsed;
        end else begin
            w_elapsed_inc = r_elapsed + EL_ONE;
        end
    end

    // Watchdog compares the count this edge will produce, so the state turns
    // TOUT on the same edge that elapsed reaches the limit.
    always_comb begin
        w_wdog_hit = 1'b0;
`ifdef SIM_SEQ_WATCHDOG_EN
        if (w_elapsed_inc >= TOUT_LIM) begin
            w_wdog_hit = 1'b1;
        end else begin
            w_wdog_hit = 1'b0;
        end
`else
        w_wdog_hit = 1'b0;
`endif
    end

    // Next-state and next-value logic for the sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_win_cnt_nxt   = r_win_cnt;
        w_done_seen_nxt = r_done_seen;
        w_fail_seen_nxt = r_fail_seen;
        w_elapsed_nxt   = r_elapsed;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_done_seen_nxt = {NO_SIG{1'b0}};
                    w_fail_seen_nxt = {NO_SIG{1'b0}};
                    w_elapsed_nxt   = {CW{1'b0}};
                    w_win_cnt_nxt   = {WIN_W{1'b0}};
                    if (ARM_SKIP) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ARM: begin
                w_elapsed_nxt = w_elapsed_inc;
                if (w_wdog_hit) begin
                    w_state_nxt = S_TOUT;
                end else if (r_win_cnt == ARM_LAST) begin
                    w_state_nxt   = S_RUN;
                    w_win_cnt_nxt = {WIN_W{1'b0}};
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_ONE;
                end
            end
            S_RUN: begin
                w_elapsed_nxt   = w_elapsed_inc;
                w_done_seen_nxt = r_done_seen | done_in;
                w_fail_seen_nxt = r_fail_seen | fail_in;
                // All-done takes priority over a watchdog hit in the same cycle.
                if (&w_done_seen_nxt) begin
                    w_win_cnt_nxt = {WIN_W{1'b0}};
                    if (DRAIN_SKIP) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_TOUT;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                // Failures still count while draining; the watchdog does not.
                w_elapsed_nxt   = w_elapsed_inc;
                w_fail_seen_nxt = r_fail_seen | fail_in;
                if (r_win_cnt == DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_win_cnt_nxt = r_win_cnt + WIN_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            S_TOUT: begin
                w_state_nxt = S_TOUT;
            end
            default: begin
                // Encodings 6/7 recover to a clean IDLE.
                w_state_nxt     = S_IDLE;
                w_win_cnt_nxt   = {WIN_W{1'b0}};
                w_done_seen_nxt = {NO_SIG{1'b0}};
                w_fail_seen_nxt = {NO_SIG{1'b0}};
                w_elapsed_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Status outputs are decoded from the next state so they register
    // together with the state transition.
    always_comb begin
        w_finish_nxt  = 1'b0;
        w_pass_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        if (w_state_nxt == S_DONE) begin
            w_finish_nxt = 1'b1;
            w_pass_nxt   = ~|w_fail_seen_nxt;
        end else if (w_state_nxt == S_TOUT) begin
            w_finish_nxt  = 1'b1;
            w_timeout_nxt = 1'b1;
        end else begin
            w_finish_nxt = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_win_cnt   <= {WIN_W{1'b0}};
            r_done_seen <= {NO_SIG{1'b0}};
            r_fail_seen <= {NO_SIG{1'b0}};
            r_elapsed   <= {CW{1'b0}};
            r_finish    <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_done_seen <= w_done_seen_nxt;
            r_fail_seen <= w_fail_seen_nxt;
            r_elapsed   <= w_elapsed_nxt;
            r_finish    <= w_finish_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    assign finish    = r_finish;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign done_seen = r_done_seen;
    assign state     = r_state;
    assign elapsed   = r_elapsed;

endmodule

// File: tb/tb_sim_done_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sim_done_sequencer
//
// Drives directed edge-numbered stimulus (edge 1 = first clock after reset
// release) into sim_done_sequencer with NO_SIG=4, ARM_CYC=4, DRAIN_CYC=3,
// TIMEOUT_CYC=50. Expected output values are queued with the edge after which
// they must hold and are compared at the following falling clock edge.
// Watchdog expectations follow SIM_SEQ_WATCHDOG_EN as seen by this compile.
// -----------------------------------------------------------------------------
module tb_sim_done_sequencer;

    localparam int SEL_ST   = 0;
    localparam int SEL_FIN  = 1;
    localparam int SEL_PASS = 2;
    localparam int SEL_TO   = 3;
    localparam int SEL_DS   = 4;
    localparam int SEL_EL   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  done_in = 4'd0;
    logic [3:0]  fail_in = 4'd0;
    logic        finish;
    logic        pass;
    logic        timeout;
    logic [3:0]  done_seen;
    logic [2:0]  state;
    logic [31:0] elapsed;

    sim_done_sequencer #(
        .NO_SIG(4), .ARM_CYC(4), .DRAIN_CYC(3), .TIMEOUT_CYC(50), .CW(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .done_in(done_in), .fail_in(fail_in),
        .finish(finish), .pass(pass), .timeout(timeout), .done_seen(done_seen),
        .state(state), .elapsed(elapsed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              at;
        int              sel;
        longint unsigned val;
        string           tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   edge_n = 0;

    task automatic check_val(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned observe(input int sel);
        case (sel)
            SEL_ST:   return longint'(state);
            SEL_FIN:  return longint'(finish);
            SEL_PASS: return longint'(pass);
            SEL_TO:   return longint'(timeout);
            SEL_DS:   return longint'(done_seen);
            SEL_EL:   return longint'(elapsed);
            default:  return 64'd0;
        endcase
    endfunction

    task automatic expect_at(input int at, input int sel, input longint unsigned val, input string tag);
        exp_t x;
        x.at  = at;
        x.sel = sel;
        x.val = val;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // One clock edge, then compare everything due after this edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_n) begin
                check_val($sformatf("%s@%0d", sb[i].tag, edge_n), observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    // Stimulus per test id and edge number.
    task automatic stim(input int t, input int e, output logic s, output logic [3:0] d, output logic [3:0] f);
        s = (e == 1) || (t == 1 && e == 7);
        d = 4'd0;
        f = 4'd0;
        case (t)
            1, 3, 4: begin
                if (e == 10) d = 4'b0001;
                if (e == 12) d = 4'b0010;
                if (e == 14) d = 4'b0100;
                if (e == 20) d = 4'b1000;
                if (t == 3 && e == 21) f = 4'b0100;
                if (t == 4 && e == 20) f = 4'b0001;
            end
            2: begin
                if ((e >= 2 && e <= 4) || e == 15) d = 4'b1111;
            end
            5, 6: begin
                if (e == 10) d = 4'b0001;
                if (e == 12) d = 4'b0010;
                if (e == 14) d = 4'b0100;
                if (t == 6 && e == 51) d = 4'b1000;
            end
            default: d = 4'd0;
        endcase
    endtask

    task automatic run(input int t, input int last_edge);
        logic       s;
        logic [3:0] d;
        logic [3:0] f;
        for (int e = 1; e <= last_edge; e++) begin
            stim(t, e, s, d, f);
            start   = s;
            done_in = d;
            fail_in = f;
            tick();
        end
        start   = 1'b0;
        done_in = 4'd0;
        fail_in = 4'd0;
        if (sb.size() != 0) begin
            check_val("sb_leftover", longint'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        start   = 1'b0;
        done_in = 4'd0;
        fail_in = 4'd0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    // Mid-cycle reset pulse; outputs must clear without a clock edge.
    task automatic async_reset_check(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_val({tag, "_state"},   longint'(state),     64'd0);
        check_val({tag, "_finish"},  longint'(finish),    64'd0);
        check_val({tag, "_pass"},    longint'(pass),      64'd0);
        check_val({tag, "_timeout"}, longint'(timeout),   64'd0);
        check_val({tag, "_dseen"},   longint'(done_seen), 64'd0);
        check_val({tag, "_elapsed"}, longint'(elapsed),   64'd0);
    endtask

    initial begin
        #1;
        check_val("rst_state",   longint'(state),     64'd0);
        check_val("rst_finish",  longint'(finish),    64'd0);
        check_val("rst_pass",    longint'(pass),      64'd0);
        check_val("rst_timeout", longint'(timeout),   64'd0);
        check_val("rst_dseen",   longint'(done_seen), 64'd0);
        check_val("rst_elapsed", longint'(elapsed),   64'd0);

        // Nominal completion, with a start pulse in RUN that must be ignored.
        do_reset();
        expect_at(1,  SEL_ST, 1, "nom_arm");
        expect_at(1,  SEL_EL, 0, "nom_el0");
        expect_at(1,  SEL_DS, 0, "nom_ds0");
        expect_at(4,  SEL_ST, 1, "nom_still_arm");
        expect_at(5,  SEL_ST, 2, "nom_run");
        expect_at(7,  SEL_ST, 2, "start_in_run_state");
        expect_at(7,  SEL_EL, 6, "start_in_run_el");
        expect_at(10, SEL_DS, 1, "nom_ds1");
        expect_at(14, SEL_DS, 7, "nom_ds7");
        expect_at(19, SEL_ST, 2, "nom_run19");
        expect_at(20, SEL_ST, 3, "nom_drain");
        expect_at(20, SEL_DS, 15, "nom_dsF");
        expect_at(20, SEL_EL, 19, "nom_el19");
        expect_at(22, SEL_FIN, 0, "nom_fin22");
        expect_at(23, SEL_ST, 4, "nom_done");
        expect_at(23, SEL_FIN, 1, "nom_fin");
        expect_at(23, SEL_PASS, 1, "nom_pass");
        expect_at(23, SEL_TO, 0, "nom_to");
        expect_at(23, SEL_EL, 22, "nom_el22");
        expect_at(30, SEL_EL, 22, "nom_el_hold");
        expect_at(30, SEL_FIN, 1, "nom_fin_hold");
        expect_at(30, SEL_ST, 4, "nom_done_hold");
        run(1, 30);

        // DONE, then reset: finish drops at once; then a clean new sequence.
        async_reset_check("done_rst");
        do_reset();
        expect_at(5,  SEL_ST, 2, "restart_run");
        expect_at(20, SEL_ST, 3, "restart_drain");
        expect_at(23, SEL_FIN, 1, "restart_fin");
        expect_at(23, SEL_PASS, 1, "restart_pass");
        expect_at(23, SEL_EL, 22, "restart_el");
        run(1, 24);

        // Arm masking.
        do_reset();
        expect_at(5,  SEL_ST, 2, "arm_run");
        expect_at(5,  SEL_DS, 0, "arm_ds0");
        expect_at(14, SEL_DS, 0, "arm_ds14");
        expect_at(15, SEL_ST, 3, "arm_drain");
        expect_at(15, SEL_DS, 15, "arm_dsF");
        expect_at(17, SEL_FIN, 0, "arm_fin17");
        expect_at(18, SEL_FIN, 1, "arm_fin18");
        expect_at(18, SEL_PASS, 1, "arm_pass");
        expect_at(18, SEL_ST, 4, "arm_done");
        run(2, 20);

        // Failure captured during DRAIN.
        do_reset();
        expect_at(21, SEL_ST, 3, "fdr_drain");
        expect_at(23, SEL_ST, 4, "fdr_done");
        expect_at(23, SEL_FIN, 1, "fdr_fin");
        expect_at(23, SEL_PASS, 0, "fdr_pass");
        run(3, 25);

        // Failure in the same cycle as the final done.
        do_reset();
        expect_at(20, SEL_ST, 3, "fsame_drain");
        expect_at(23, SEL_FIN, 1, "fsame_fin");
        expect_at(23, SEL_PASS, 0, "fsame_pass");
        run(4, 24);

        // Watchdog: bit 3 never reports done.
        do_reset();
`ifdef SIM_SEQ_WATCHDOG_EN
        expect_at(50, SEL_ST, 2, "wd_run50");
        expect_at(50, SEL_EL, 49, "wd_el49");
        expect_at(50, SEL_FIN, 0, "wd_fin50");
        expect_at(51, SEL_ST, 5, "wd_tout");
        expect_at(51, SEL_EL, 50, "wd_el50");
        expect_at(51, SEL_FIN, 1, "wd_fin");
        expect_at(51, SEL_TO, 1, "wd_to");
        expect_at(51, SEL_PASS, 0, "wd_pass");
        expect_at(60, SEL_ST, 5, "wd_tout_hold");
        expect_at(60, SEL_EL, 50, "wd_el_hold");
        expect_at(60, SEL_FIN, 1, "wd_fin_hold");
        expect_at(60, SEL_TO, 1, "wd_to_hold");
        expect_at(60, SEL_PASS, 0, "wd_pass_hold");
        run(5, 60);
`else
        expect_at(51,  SEL_ST, 2, "nowd_run51");
        expect_at(51,  SEL_EL, 50, "nowd_el50");
        expect_at(51,  SEL_TO, 0, "nowd_to51");
        expect_at(200, SEL_FIN, 0, "nowd_fin200");
        expect_at(200, SEL_ST, 2, "nowd_run200");
        expect_at(200, SEL_EL, 199, "nowd_el199");
        expect_at(200, SEL_TO, 0, "nowd_to200");
        run(5, 200);
`endif

        // Final done on the watchdog cycle: all-done wins.
        do_reset();
        expect_at(50, SEL_ST, 2, "bnd_run50");
        expect_at(51, SEL_ST, 3, "bnd_drain");
        expect_at(51, SEL_EL, 50, "bnd_el50");
        expect_at(51, SEL_TO, 0, "bnd_to51");
        expect_at(53, SEL_FIN, 0, "bnd_fin53");
        expect_at(54, SEL_ST, 4, "bnd_done");
        expect_at(54, SEL_FIN, 1, "bnd_fin");
        expect_at(54, SEL_PASS, 1, "bnd_pass");
        expect_at(54, SEL_TO, 0, "bnd_to");
        expect_at(54, SEL_EL, 53, "bnd_el53");
        run(6, 56);

        // Reset asserted mid-DRAIN.
        do_reset();
        expect_at(20, SEL_ST, 3, "mid_drain20");
        expect_at(21, SEL_ST, 3, "mid_drain21");
        expect_at(21, SEL_DS, 15, "mid_dsF");
        run(1, 21);
        async_reset_check("drain_rst");
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
